data_mem_bank: RTL
==================

Name: data_mem_bank

Overview:
- Parametrised successor to the single-port data memory, with DATA_WIDTH-bit words, per-byte write enables and a registered read response.
- Bulk zeroing is done by a sequential clear engine, both automatically after reset and on request. The memory array itself is not reset asynchronously.
- Requests use a valid/ready handshake. Out-of-range addresses are flagged when MEMORY_SIZE is not a power of two.
- Sits between the datapath load/store unit and the local data storage.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- MEMORY_SIZE, 64, number of words; any value >= 2.
- ADDR_W, $clog2(MEMORY_SIZE), address width; derived, not overridden.
- BE_W, DATA_WIDTH/8, byte-enable width; derived.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  BE_W  byte enables; bit k covers bits [8k+7:8k].
- rsp_valid  out  1  read data valid (one-cycle pulse).
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_err  out  1  accepted request had addr >= MEMORY_SIZE (one-cycle pulse).
- clear_req  in  1  start a full-memory clear.
- clear_busy  out  1  clear engine active.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to CLEAR, clr_ptr=0.
  - Outputs: rsp_valid=0, rsp_rdata=0, rsp_err=0, clear_busy=1, req_ready=0.
  - Array contents are not touched during reset.
- FSM states, CLEAR and IDLE:
  - CLEAR: each cycle writes all-zero to mem[clr_ptr], then clr_ptr++. When clr_ptr==MEMORY_SIZE-1 is written, the next state is IDLE and clr_ptr returns to 0.
  - A full clear takes exactly MEMORY_SIZE cycles.
  - IDLE: clear_req=1 sampled at an edge moves the FSM to CLEAR at that edge.
  - clear_req while already in CLEAR is ignored; the clear is not restarted.
- Outputs by state:
  - req_ready = (state==IDLE). Purely combinational from state, independent of req_valid and clear_req.
  - clear_busy = (state==CLEAR).
- Acceptance: a request is accepted at an edge where req_valid && req_ready.
  - If clear_req is high in the same cycle, the request still completes. The clear starts at that edge and then overwrites memory.
- Write handling (accepted, addr < MEMORY_SIZE):
  - For each k with req_be[k]=1, byte k of mem[addr] takes req_wdata byte k.
  - Other bytes hold their value.
  - req_be=0 performs no update.
  - No rsp_valid is generated for writes.
- Read handling (accepted, addr < MEMORY_SIZE):
  - rsp_valid=1 and rsp_rdata=mem[addr] in the cycle after the acceptance edge (latency 1).
  - req_be is ignored for reads.
  - rsp_rdata holds its last value while rsp_valid=0.
- Out-of-range address (addr >= MEMORY_SIZE):
  - A write is dropped with no array change.
  - A read returns rsp_rdata=0 with rsp_valid=1.
  - In both cases rsp_err=1 for one cycle, aligned with where rsp_valid would be.
- Back-to-back traffic:
  - One request per cycle, full throughput in IDLE.
  - A read following a write to the same address on the next cycle returns the new data, because the write completed at the earlier edge.
- Reset mid-clear or mid-read:
  - Any pending rsp is discarded (rsp_valid=0) and the clear restarts from clr_ptr=0.
  - Partially cleared contents are irrelevant because the restarted clear zeroes every word.

Decomposition:
- Shared package data_mem_pkg:
  - state typedef {CLEAR, IDLE}.
  - Helper function for ADDR_W/BE_W derivation.
- Sub-module data_mem_array: synchronous, byte-enabled, single-port array with 1-cycle registered read and no reset.
  - The FSM, clear mux, range check and response registers live in data_mem_bank.

Test Plan:
- Post-reset clear: release reset with DATA_WIDTH=32, MEMORY_SIZE=64 -> clear_busy=1 and req_ready=0 for exactly 64 cycles, then req_ready=1. A read of addr 63 then returns 0x00000000.
- Byte-enable write: write 0xAABBCCDD be=4'b1111 to addr 5, then write 0x11223344 be=4'b0101 to addr 5, then read addr 5 -> rsp_valid one cycle after acceptance, rsp_rdata=0xAA22CC44.
- Back-to-back: write 0xDEADBEEF to addr 7 at cycle N, read addr 7 at N+1 -> rsp_valid at N+2 with 0xDEADBEEF. Also check req_ready stays 1 throughout.
- Out-of-range (MEMORY_SIZE=48): write 0x12345678 to addr 50, then read addr 50 -> rsp_err pulses once for each access; the read gives rsp_valid=1 with rsp_rdata=0. A read of addr 47 is unaffected.
- Clear request concurrent with write: in IDLE, assert clear_req and a write of 0xFFFFFFFF to addr 3 in the same cycle -> clear_busy=1 for 64 cycles, then a read of addr 3 returns 0.
- Reset mid-operation: assert reset during CLEAR at clr_ptr=20 and again one cycle after a read is accepted -> rsp_valid never pulses, and the clear runs a full 64 cycles after each release.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and width helpers for the data memory bank and its storage array.
// Pure declarations, no logic.
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    function automatic int addr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port byte-enabled storage, 1-cycle registered read, no reset.
// Read data register only updates on a read strobe, so it holds otherwise.
module data_mem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEMORY_SIZE = 64,
    parameter int ADDR_W      = 6,
    parameter int BE_W        = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [BE_W-1:0]       i_be,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEMORY_SIZE];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (i_be[k]) begin
                    r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_bank.sv
// Byte-enabled data memory with valid/ready requests, 1-cycle read response and a
// sequential clear engine; req_ready drops for exactly MEMORY_SIZE cycles per clear.
module data_mem_bank
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEMORY_SIZE = 64,
    parameter int ADDR_W      = addr_width(MEMORY_SIZE),
    parameter int BE_W        = be_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_W-1:0]       req_be,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    input  logic                  clear_req,
    output logic                  clear_busy
);

    localparam logic [ADDR_W:0]   LP_SIZE = (ADDR_W+1)'(MEMORY_SIZE);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(MEMORY_SIZE - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_clr_ptr;
    logic [ADDR_W-1:0]     w_clr_ptr_nxt;

    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_rsp_oor;
    logic [DATA_WIDTH-1:0] r_rdata_last;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_arr_we;
    logic                  w_arr_re;
    logic [ADDR_W-1:0]     w_arr_addr;
    logic [DATA_WIDTH-1:0] w_arr_wdata;
    logic [BE_W-1:0]       w_arr_be;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            CLEAR: begin
                if (r_clr_ptr == LP_LAST) begin
                    w_state_nxt   = IDLE;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    assign req_ready  = (r_state == IDLE);
    assign clear_busy = (r_state == CLEAR);

    assign w_accept   = req_valid && req_ready;
    assign w_in_range = ({1'b0, req_addr} < LP_SIZE);

    // The clear engine owns the array port whenever it is running.
    assign w_arr_we    = clear_busy || (w_accept && req_write && w_in_range);
    assign w_arr_re    = w_accept && !req_write && w_in_range;
    assign w_arr_addr  = clear_busy ? r_clr_ptr : req_addr;
    assign w_arr_wdata = clear_busy ? '0 : req_wdata;
    assign w_arr_be    = clear_busy ? '1 : req_be;

    data_mem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MEMORY_SIZE (MEMORY_SIZE),
        .ADDR_W      (ADDR_W),
        .BE_W        (BE_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .i_be    (w_arr_be),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_oor    <= 1'b0;
            r_rdata_last <= '0;
        end else begin
            r_rsp_valid <= w_accept && !req_write;
            r_rsp_err   <= w_accept && !w_in_range;
            r_rsp_oor   <= !w_in_range;
            if (r_rsp_valid) begin
                r_rdata_last <= rsp_rdata;
            end
        end
    end

    // Array read register is unreset, so the held copy supplies rsp_rdata between pulses.
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_valid ? (r_rsp_oor ? '0 : w_arr_rdata) : r_rdata_last;

endmodule
